// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and one register-file completer (slave).
interface apb_slave_regfile_if;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Psel, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Psel, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer answering one Pselx line with a word-addressed register file,
// programmable wait states and an error response for out-of-range or misaligned accesses.
module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    apb_slave_regfile_if.slave apb
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        ACC
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              in_range_q, in_range_d;
    logic [31:0]       prdata_q, prdata_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [31:0]       mem_q [DEPTH];

    logic [31:0]       offset;
    logic              addr_ok;
    logic [IDX_W-1:0]  addr_index;
    logic              mem_we;
    logic              wait_done;
    logic              proto_err;

    // Address decode is evaluated on the live bus so it can be latched at the SETUP edge.
    assign offset     = apb.Paddr - BASE_ADDR;
    assign addr_ok    = (offset < SPAN) && (apb.Paddr[1:0] == 2'b00);
    assign addr_index = offset[IDX_W+1:2];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        write_d    = write_q;
        index_d    = index_q;
        in_range_d = in_range_q;
        prdata_d   = prdata_q;
        valid_d    = valid_q;
        mem_we     = 1'b0;

        // A SETUP restarts the transfer whether we were idle or still in ACCESS.
        if (apb.Psel && !apb.Penable) begin
            state_d    = ACC;
            count_d    = 4'd0;
            write_d    = apb.Pwrite;
            index_d    = addr_index;
            in_range_d = addr_ok;
            if (!apb.Pwrite) begin
                prdata_d = (addr_ok && valid_q[addr_index]) ? mem_q[addr_index] : 32'h0;
            end
        end else if (state_q == ACC) begin
            if (!apb.Psel) begin
                state_d = IDLE;
            end else if (apb.Penable) begin
                if (count_q == WAIT_LAST) begin
                    state_d = IDLE;
                    mem_we  = write_q && in_range_q;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
        end

        if (mem_we) begin
            valid_d[index_q] = 1'b1;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            write_q    <= 1'b0;
            index_q    <= '0;
            in_range_q <= 1'b0;
            prdata_q   <= 32'h0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            write_q    <= write_d;
            index_q    <= index_d;
            in_range_q <= in_range_d;
            prdata_q   <= prdata_d;
            valid_q    <= valid_d;
        end
    end

    // Storage is deliberately unreset; the valid bits make unwritten words read as zero.
    always_ff @(posedge Hclk) begin
        if (mem_we) begin
            mem_q[index_q] <= apb.Pwdata;
        end
    end

    assign wait_done   = (state_q == ACC) && (count_q == WAIT_LAST);
    assign proto_err   = (state_q == IDLE) && apb.Psel && apb.Penable;
    assign apb.Pready  = Hresetn && (wait_done || proto_err);
    assign apb.Pslverr = Hresetn && ((wait_done && !in_range_q) || proto_err);
    assign apb.Prdata  = prdata_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait states) driven by vector tables,
// hand sequences for abort/reset/protocol-violation and random traffic against a reference model.
module tb_apb_slave_regfile;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          NWORDS = 16;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  psel;
    logic [1:0]  penable;
    logic [1:0]  pwrite;
    logic [31:0] paddr  [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];
    logic [1:0]  pready;
    logic [1:0]  pslverr;

    int tests_run;
    int tests_failed;

    logic [31:0] model_mem [2][NWORDS];
    logic [31:0] model_rd  [2];

    apb_slave_regfile_if bus0 ();
    apb_slave_regfile_if bus1 ();

    assign bus0.Psel    = psel[0];
    assign bus0.Penable = penable[0];
    assign bus0.Pwrite  = pwrite[0];
    assign bus0.Paddr   = paddr[0];
    assign bus0.Pwdata  = pwdata[0];
    assign bus1.Psel    = psel[1];
    assign bus1.Penable = penable[1];
    assign bus1.Pwrite  = pwrite[1];
    assign bus1.Paddr   = paddr[1];
    assign bus1.Pwdata  = pwdata[1];
    assign prdata[0]    = bus0.Prdata;
    assign prdata[1]    = bus1.Prdata;
    assign pready       = {bus1.Pready, bus0.Pready};
    assign pslverr      = {bus1.Pslverr, bus0.Pslverr};

    apb_slave_regfile #(.BASE_ADDR(BASE), .DEPTH(NWORDS), .WAIT_STATES(0)) dut0 (
        .Hclk(hclk), .Hresetn(hresetn), .apb(bus0)
    );
    apb_slave_regfile #(.BASE_ADDR(BASE), .DEPTH(NWORDS), .WAIT_STATES(3)) dut3 (
        .Hclk(hclk), .Hresetn(hresetn), .apb(bus1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int wait_states_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            model_rd[d] = 32'h0;
            for (int i = 0; i < NWORDS; i++) model_mem[d][i] = 32'h0;
        end
    endfunction

    // Reference behaviour: in-range aligned writes store, reads return the stored word or 0,
    // writes leave the read-data register untouched.
    function automatic void model_apply(input int d, input logic wr, input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        output logic [31:0] exp_rdata, output logic exp_err);
        logic [31:0] off;
        logic        ok;
        int          idx;
        off = addr - BASE;
        ok  = (off < 32'(4 * NWORDS)) && (addr % 4 == 0);
        idx = ok ? int'(off / 4) : 0;
        exp_err = !ok;
        if (wr) begin
            if (ok) model_mem[d][idx] = wdata;
        end else begin
            model_rd[d] = ok ? model_mem[d][idx] : 32'h0;
        end
        exp_rdata = model_rd[d];
    endfunction

    task automatic bus_idle();
        psel    = 2'b00;
        penable = 2'b00;
    endtask

    // Called just after a rising edge; leaves the bus asserted so transfers chain back-to-back.
    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int waits,
                                 output logic stable, output logic done);
        logic [31:0] first;
        psel[1-d]    = 1'b0;
        penable[1-d] = 1'b0;
        psel[d]      = 1'b1;
        penable[d]   = 1'b0;
        pwrite[d]    = wr;
        paddr[d]     = addr;
        pwdata[d]    = wdata;
        @(posedge hclk); #1;
        penable[d] = 1'b1;
        pwrite[d]  = ~wr;
        paddr[d]   = ~addr;
        @(negedge hclk);
        first  = prdata[d];
        stable = 1'b1;
        waits  = 0;
        while (!pready[d] && waits < 20) begin
            waits++;
            @(negedge hclk);
            if (prdata[d] !== first) stable = 1'b0;
        end
        rdata = prdata[d];
        err   = pslverr[d];
        done  = pready[d];
        @(posedge hclk); #1;
    endtask

    task automatic run_vector(input string name, input int d, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_waits);
        logic [31:0] rdata;
        logic        err, stable, done;
        int          waits;
        applyStimulus(d, wr, addr, wdata, rdata, err, waits, stable, done);
        checkOutput($sformatf("%s done", name), 32'(done), 32'd1);
        checkOutput($sformatf("%s rdata", name), rdata, exp_rdata);
        checkOutput($sformatf("%s slverr", name), 32'(err), 32'(exp_err));
        checkOutput($sformatf("%s waits", name), 32'(waits), 32'(exp_waits));
        checkOutput($sformatf("%s stable", name), 32'(stable), 32'd1);
    endtask

    task automatic run_model(input string name, input int d, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rdata;
        logic        exp_err;
        model_apply(d, wr, addr, wdata, exp_rdata, exp_err);
        run_vector(name, d, wr, addr, wdata, exp_rdata, exp_err, wait_states_of(d));
    endtask

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] scratch_rd;
        logic        scratch_err;
        logic [31:0] addr;
        int          d, sel;

        tests_run    = 0;
        tests_failed = 0;
        vecs[0]  = '{0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0};
        vecs[1]  = '{0, 1'b0, 32'h8000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
        vecs[2]  = '{0, 1'b0, 32'h8000_000C, 32'h0,         32'h0000_0000, 1'b0, 0};
        vecs[3]  = '{0, 1'b1, 32'h8000_0040, 32'h1234_5678, 32'h0000_0000, 1'b1, 0};
        vecs[4]  = '{0, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b0, 0};
        vecs[5]  = '{0, 1'b0, 32'h8000_0002, 32'h0,         32'h0000_0000, 1'b1, 0};
        vecs[6]  = '{0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 0};
        vecs[7]  = '{0, 1'b0, 32'h8000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, 0};
        vecs[8]  = '{0, 1'b1, 32'h8000_003C, 32'hA5A5_5A5A, 32'hCAFE_F00D, 1'b0, 0};
        vecs[9]  = '{0, 1'b0, 32'h8000_003C, 32'h0,         32'hA5A5_5A5A, 1'b0, 0};
        vecs[10] = '{0, 1'b0, 32'h7FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 0};
        vecs[11] = '{1, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b0, 3};
        vecs[12] = '{1, 1'b1, 32'h8000_0004, 32'h1111_2222, 32'h0000_0000, 1'b0, 3};
        vecs[13] = '{1, 1'b0, 32'h8000_0004, 32'h0,         32'h1111_2222, 1'b0, 3};
        vecs[14] = '{1, 1'b0, 32'h8000_0041, 32'h0,         32'h0000_0000, 1'b1, 3};

        hresetn   = 1'b0;
        psel      = 2'b00;
        penable   = 2'b00;
        pwrite    = 2'b00;
        paddr[0]  = 32'h0;
        paddr[1]  = 32'h0;
        pwdata[0] = 32'h0;
        pwdata[1] = 32'h0;
        model_reset();

        // Outputs must stay low while reset is held, even with Psel&Penable applied.
        #3;
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        #10;
        checkOutput("reset pready", 32'(pready[0]), 32'd0);
        checkOutput("reset pslverr", 32'(pslverr[0]), 32'd0);
        checkOutput("reset prdata0", prdata[0], 32'h0);
        checkOutput("reset prdata3", prdata[1], 32'h0);
        bus_idle();
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk); #1;
        checkOutput("idle pready", 32'(pready), 32'd0);

        for (int i = 0; i < 15; i++) begin
            model_apply(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, scratch_rd, scratch_err);
            run_vector($sformatf("vec%0d", i), vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_waits);
        end

        // Abort a 3-wait-state write after one ACCESS cycle, then probe IDLE with a protocol violation.
        bus_idle();
        psel[1]    = 1'b1;
        pwrite[1]  = 1'b1;
        paddr[1]   = 32'h8000_0004;
        pwdata[1]  = 32'hBAD0_0001;
        @(posedge hclk); #1;
        penable[1] = 1'b1;
        @(negedge hclk);
        checkOutput("abort access pready", 32'(pready[1]), 32'd0);
        @(posedge hclk); #1;
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        @(negedge hclk);
        checkOutput("abort dropped pready", 32'(pready[1]), 32'd0);
        @(posedge hclk); #1;
        psel[1]    = 1'b1;
        penable[1] = 1'b1;
        @(negedge hclk);
        checkOutput("abort idle pready", 32'(pready[1]), 32'd1);
        checkOutput("abort idle pslverr", 32'(pslverr[1]), 32'd1);
        @(posedge hclk); #1;
        bus_idle();
        run_model("abort readback", 1, 1'b0, 32'h8000_0004, 32'h0);

        // Protocol violation on the zero-wait instance: immediate error, nothing stored.
        bus_idle();
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        pwrite[0]  = 1'b1;
        paddr[0]   = 32'h8000_0008;
        pwdata[0]  = 32'hFFFF_FFFF;
        @(negedge hclk);
        checkOutput("violation pready", 32'(pready[0]), 32'd1);
        checkOutput("violation pslverr", 32'(pslverr[0]), 32'd1);
        @(posedge hclk); #1;
        bus_idle();
        @(posedge hclk); #1;
        run_model("violation readback", 0, 1'b0, 32'h8000_0008, 32'h0);

        // Reset asserted during ACCESS of a write aborts it and clears Prdata.
        bus_idle();
        psel[1]   = 1'b1;
        pwrite[1] = 1'b1;
        paddr[1]  = 32'h8000_0008;
        pwdata[1] = 32'h7777_7777;
        @(posedge hclk); #1;
        penable[1] = 1'b1;
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        checkOutput("midreset prdata3", prdata[1], 32'h0);
        checkOutput("midreset prdata0", prdata[0], 32'h0);
        checkOutput("midreset pready", 32'(pready[1]), 32'd0);
        checkOutput("midreset pslverr", 32'(pslverr[1]), 32'd0);
        @(posedge hclk); #1;
        bus_idle();
        @(negedge hclk);
        hresetn = 1'b1;
        model_reset();
        @(posedge hclk); #1;
        run_model("postreset read3", 1, 1'b0, 32'h8000_0008, 32'h0);
        run_model("postreset read0", 0, 1'b0, 32'h8000_0008, 32'h0);

        for (int i = 0; i < 80; i++) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       addr = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
            else if (sel == 8) addr = BASE + 32'(4 * $urandom_range(0, NWORDS - 1)) + 32'($urandom_range(1, 3));
            else               addr = BASE + 32'(4 * NWORDS) + 32'(4 * $urandom_range(0, 63));
            run_model($sformatf("rand%0d", i), d, 1'($urandom), addr, $urandom);
        end

        bus_idle();
        @(posedge hclk); #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
